// File: rtl/tank_bullet_ctrl.sv
// rtl/tank_bullet_ctrl.sv - per-tank shell spawner/mover, one update per frame_clk edge.
// Optional macro BULLET_BOUNCE_EN: reflect off playfield edges instead of expiring.
module tank_bullet_ctrl #(
  parameter int          MAX_BULLETS = 4,
  parameter logic [7:0]  FIRE_KEY    = 8'h2C,
  parameter int          SPEED       = 4,
  parameter int          LIFETIME    = 300,
  parameter int          COOLDOWN    = 15,
  parameter int          X_MIN       = 0,
  parameter int          X_MAX       = 639,
  parameter int          Y_MIN       = 0,
  parameter int          Y_MAX       = 479
) (
  input  logic                        frame_clk,
  input  logic                        Reset,
  input  logic [31:0]                 keycode,
  input  logic [9:0]                  TankX,
  input  logic [9:0]                  TankY,
  input  logic [7:0]                  sin,
  input  logic [7:0]                  cos,
  output logic [10*MAX_BULLETS-1:0]   BulletX,
  output logic [10*MAX_BULLETS-1:0]   BulletY,
  output logic [MAX_BULLETS-1:0]      BulletActive,
  output logic                        FirePulse,
  output logic [3:0]                  BulletCount
);

  localparam logic signed [15:0] SPEED_S  = 16'(SPEED);
  localparam logic signed [10:0] XMIN_S   = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S   = 11'(X_MAX);
  localparam logic signed [10:0] YMIN_S   = 11'(Y_MIN);
  localparam logic signed [10:0] YMAX_S   = 11'(Y_MAX);
  localparam logic [9:0]         XMIN_V   = 10'(X_MIN);
  localparam logic [9:0]         XMAX_V   = 10'(X_MAX);
  localparam logic [9:0]         YMIN_V   = 10'(Y_MIN);
  localparam logic [9:0]         YMAX_V   = 10'(Y_MAX);
  localparam logic [8:0]         LIFE_V   = 9'(LIFETIME);
  localparam logic [7:0]         COOL_V   = 8'(COOLDOWN);

  logic [MAX_BULLETS-1:0][9:0]  pos_x;
  logic [MAX_BULLETS-1:0][9:0]  pos_y;
  logic [MAX_BULLETS-1:0][7:0]  vel_x;
  logic [MAX_BULLETS-1:0][7:0]  vel_y;
  logic [MAX_BULLETS-1:0][8:0]  life;
  logic [MAX_BULLETS-1:0]       active;
  logic [7:0]                   cooldown;
  logic                         fire_prev;

  logic                         fire_now;
  logic                         has_free;
  logic [2:0]                   alloc_idx;
  logic                         accept;
  logic signed [15:0]           prod_x;
  logic signed [15:0]           prod_y;
  logic [7:0]                   spawn_vx;
  logic [7:0]                   spawn_vy;
  logic [MAX_BULLETS-1:0][10:0] next_x;
  logic [MAX_BULLETS-1:0][10:0] next_y;
  logic [MAX_BULLETS-1:0]       lo_x, hi_x, lo_y, hi_y;
  logic [MAX_BULLETS-1:0]       act_next;
  logic [3:0]                   count_next;

  assign BulletX      = pos_x;
  assign BulletY      = pos_y;
  assign BulletActive = active;

  always_comb begin
    fire_now = (keycode[7:0]   == FIRE_KEY) || (keycode[15:8]  == FIRE_KEY) ||
               (keycode[23:16] == FIRE_KEY) || (keycode[31:24] == FIRE_KEY);
  end

  // Descending scan so the lowest free index is the one left standing.
  always_comb begin
    has_free  = 1'b0;
    alloc_idx = 3'd0;
    for (int i = MAX_BULLETS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        has_free  = 1'b1;
        alloc_idx = 3'(i);
      end
    end
  end

  assign accept = fire_now && !fire_prev && (cooldown == 8'd0) && has_free;

  // Q1.7 direction times speed; >>>7 floors toward -inf, then keep 8 bits.
  assign prod_x   = $signed({{8{cos[7]}}, cos}) * SPEED_S;
  assign prod_y   = $signed({{8{sin[7]}}, sin}) * SPEED_S;
  assign spawn_vx = 8'(prod_x >>> 7);
  assign spawn_vy = 8'(prod_y >>> 7);

  always_comb begin
    for (int i = 0; i < MAX_BULLETS; i++) begin
      next_x[i] = $signed({1'b0, pos_x[i]}) + $signed({{3{vel_x[i][7]}}, vel_x[i]});
      next_y[i] = $signed({1'b0, pos_y[i]}) + $signed({{3{vel_y[i][7]}}, vel_y[i]});
      lo_x[i]   = $signed(next_x[i]) < XMIN_S;
      hi_x[i]   = $signed(next_x[i]) > XMAX_S;
      lo_y[i]   = $signed(next_y[i]) < YMIN_S;
      hi_y[i]   = $signed(next_y[i]) > YMAX_S;
    end
  end

  always_comb begin
    act_next   = active;
    count_next = 4'd0;
    for (int i = 0; i < MAX_BULLETS; i++) begin
      if (accept && (alloc_idx == 3'(i))) begin
        act_next[i] = 1'b1;
      end else if (active[i]) begin
        if (life[i] == 9'd1) begin
          act_next[i] = 1'b0;
        end
`ifndef BULLET_BOUNCE_EN
        else if (lo_x[i] || hi_x[i] || lo_y[i] || hi_y[i]) begin
          act_next[i] = 1'b0;
        end
`endif
      end
      count_next = count_next + 4'(act_next[i]);
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      pos_x       <= '0;
      pos_y       <= '0;
      vel_x       <= '0;
      vel_y       <= '0;
      life        <= '0;
      active      <= '0;
      cooldown    <= 8'd0;
      fire_prev   <= 1'b0;
      FirePulse   <= 1'b0;
      BulletCount <= 4'd0;
    end else begin
      fire_prev   <= fire_now;
      FirePulse   <= accept;
      BulletCount <= count_next;
      active      <= act_next;

      if (accept) begin
        cooldown <= COOL_V;
      end else if (cooldown != 8'd0) begin
        cooldown <= cooldown - 8'd1;
      end

      for (int i = 0; i < MAX_BULLETS; i++) begin
        if (accept && (alloc_idx == 3'(i))) begin
          pos_x[i] <= TankX;
          pos_y[i] <= TankY;
          vel_x[i] <= spawn_vx;
          vel_y[i] <= spawn_vy;
          life[i]  <= LIFE_V;
        end else if (active[i] && (life[i] != 9'd1)) begin
          life[i] <= life[i] - 9'd1;
`ifdef BULLET_BOUNCE_EN
          // Each axis reflects independently; a corner hit flips both.
          if (lo_x[i] || hi_x[i]) begin
            pos_x[i] <= lo_x[i] ? XMIN_V : XMAX_V;
            vel_x[i] <= 8'(-$signed(vel_x[i]));
          end else begin
            pos_x[i] <= next_x[i][9:0];
          end
          if (lo_y[i] || hi_y[i]) begin
            pos_y[i] <= lo_y[i] ? YMIN_V : YMAX_V;
            vel_y[i] <= 8'(-$signed(vel_y[i]));
          end else begin
            pos_y[i] <= next_y[i][9:0];
          end
`else
          if (!(lo_x[i] || hi_x[i] || lo_y[i] || hi_y[i])) begin
            pos_x[i] <= next_x[i][9:0];
            pos_y[i] <= next_y[i][9:0];
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_tank_bullet_ctrl.sv
// tb/tb_tank_bullet_ctrl.sv - directed self-checking bench for tank_bullet_ctrl.
module tb_tank_bullet_ctrl;

  logic        frame_clk;
  logic        Reset;
  logic [31:0] keycode;
  logic [9:0]  TankX, TankY;
  logic [7:0]  sin_v, cos_v;

  logic [39:0] bx, by, lbx, lby;
  logic [3:0]  ba, lba, bc, lbc;
  logic        fp, lfp;

  int checks = 0;
  int errors = 0;

  tank_bullet_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
    .TankX(TankX), .TankY(TankY), .sin(sin_v), .cos(cos_v),
    .BulletX(bx), .BulletY(by), .BulletActive(ba),
    .FirePulse(fp), .BulletCount(bc)
  );

  tank_bullet_ctrl #(.LIFETIME(10)) dut_l (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
    .TankX(TankX), .TankY(TankY), .sin(sin_v), .cos(cos_v),
    .BulletX(lbx), .BulletY(lby), .BulletActive(lba),
    .FirePulse(lfp), .BulletCount(lbc)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1; keycode = '0; TankX = '0; TankY = '0; sin_v = '0; cos_v = '0;
    tick(); tick();
    check("rst_active", ba, 0);
    check("rst_x", bx, 0);
    check("rst_y", by, 0);
    check("rst_pulse", fp, 0);
    check("rst_count", bc, 0);
    Reset = 1'b0;
    tick();
    check("idle_active", ba, 0);

    // Phase A: spawn, motion, tank motion ignored, short lifetime
    TankX = 10'd300; TankY = 10'd250; cos_v = 8'd127; sin_v = 8'd0; keycode = 32'h0000_002C;
    tick();
    check("spawn_pulse", fp, 1);
    check("spawn_active", ba, 4'b0001);
    check("spawn_x", bx[9:0], 300);
    check("spawn_y", by[9:0], 250);
    check("spawn_count", bc, 1);
    check("l_spawn_active", lba, 4'b0001);
    keycode = 32'h0; TankX = 10'd100; TankY = 10'd50; cos_v = 8'd0;
    tick();
    check("move1_x", bx[9:0], 303);
    check("move1_y", by[9:0], 250);
    check("move1_pulse", fp, 0);
    tick();
    check("move2_x", bx[9:0], 306);
    for (int k = 3; k <= 9; k++) begin
      tick();
      check("l_alive", lba[0], 1);
      check("move_x", bx[9:0], 64'(300 + 3 * k));
    end
    tick();
    check("l_expired", lba, 0);
    check("l_count0", lbc, 0);
    check("long_alive", ba, 4'b0001);
    check("move10_x", bx[9:0], 330);

    // Phase B: hold-once, cooldown refusal and boundary, async reset
    do_reset();
    TankX = 10'd300; TankY = 10'd250; cos_v = 8'd127; sin_v = 8'd0; keycode = 32'h2C00_0000;
    tick();
    check("hold_first_pulse", fp, 1);
    for (int k = 1; k <= 19; k++) begin
      tick();
      check("hold_no_pulse", fp, 0);
      check("hold_count", bc, 1);
    end
    keycode = 32'h0; tick();
    keycode = 32'h0000_2C00; tick();
    check("s1_pulse", fp, 1);
    check("s1_active", ba, 4'b0011);
    check("s1_x", bx[19:10], 300);
    check("s0_x_moved", bx[9:0], 363);
    keycode = 32'h0; repeat (4) tick();
    keycode = 32'h002C_0000; tick();
    check("cd5_refused", fp, 0);
    check("cd5_count", bc, 2);
    keycode = 32'h0; repeat (9) tick();
    keycode = 32'h0000_002C; tick();
    check("cd15_refused", fp, 0);
    keycode = 32'h0; tick();
    keycode = 32'h0000_002C; tick();
    check("s2_pulse", fp, 1);
    check("s2_active", ba, 4'b0111);
    check("s2_count", bc, 3);
    keycode = 32'h0; tick(); tick();
    #2 Reset = 1'b1;
    #1;
    check("async_active", ba, 0);
    check("async_x", bx, 0);
    check("async_y", by, 0);
    check("async_pulse", fp, 0);
    check("async_count", bc, 0);

    // Phase C: key held across reset release, fill all slots, refuse fifth
    keycode = 32'h0000_002C;
    tick();
    Reset = 1'b0;
    tick();
    check("held_fire_pulse", fp, 1);
    check("held_fire_active", ba, 4'b0001);
    for (int j = 2; j <= 4; j++) begin
      keycode = 32'h0; repeat (15) tick();
      keycode = 32'h0000_002C; tick();
      check("fill_pulse", fp, 1);
      check("fill_count", bc, 64'(j));
    end
    keycode = 32'h0; repeat (15) tick();
    keycode = 32'h0000_002C; tick();
    check("full_pulse", fp, 0);
    check("full_count", bc, 4);
    check("full_active", ba, 4'hF);

    // Phase D: playfield edge on both axes in one frame
    keycode = 32'h0;
    do_reset();
    TankX = 10'd637; TankY = 10'd2; cos_v = 8'd127; sin_v = 8'h80; keycode = 32'h0000_002C;
    tick();
    check("edge_spawn_x", bx[9:0], 637);
    check("edge_spawn_y", by[9:0], 2);
    keycode = 32'h0;
    tick();
`ifdef BULLET_BOUNCE_EN
    check("bounce_active", ba, 4'b0001);
    check("bounce_x", bx[9:0], 639);
    check("bounce_y", by[9:0], 0);
    tick();
    check("bounce_x2", bx[9:0], 636);
    check("bounce_y2", by[9:0], 4);
`else
    check("edge_cleared", ba, 0);
    check("edge_count", bc, 0);
    tick();
    check("edge_stays_clear", ba, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
